// File: rtl/cbus_writeback_buffer_pkg.sv
// Shared cbus typedefs, write-back buffer state encoding and line helpers.
package cbus_writeback_buffer_pkg;

    localparam int WB_LINE_WORDS = 4;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {IDLE, ABSORB, PASS, DRAIN} wb_state_t;

    // Base byte address of the line containing addr.
    function automatic logic [31:0] line_base(input logic [31:0] addr, input int offset_bits);
        logic [31:0] mask;
        mask = ~((32'd1 << offset_bits) - 32'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/cbus_writeback_buffer_line_store.sv
// Single-line storage for the write-back buffer: word array, line tag, valid.
module wb_line_store #(
    parameter int LINE_WORDS = 4,
    parameter int IDXW       = $clog2(LINE_WORDS)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            we,
    input  logic [IDXW-1:0] widx,
    input  logic [31:0]     wdata,
    input  logic [31:0]     wtag,
    input  logic            set_valid,
    input  logic            clr_valid,
    input  logic [IDXW-1:0] ridx,
    output logic [31:0]     rdata,
    output logic            valid,
    output logic [31:0]     tag
);

    logic [LINE_WORDS-1:0][31:0] words;

    // Word and tag capture, one beat per cycle while absorbing.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            words <= '0;
            tag   <= '0;
        end else if (we) begin
            words[widx] <= wdata;
            tag         <= wtag;
        end
    end

    // Line becomes valid on the final absorb beat, invalid once drained.
    always_ff @(posedge clk) begin
        if (!resetn)        valid <= 1'b0;
        else if (set_valid) valid <= 1'b1;
        else if (clr_valid) valid <= 1'b0;
    end

    assign rdata = words[ridx];

endmodule

// File: rtl/cbus_writeback_buffer.sv
// Single-line write-back buffer between DCache and memory on the cbus path.
// Optional macro WB_FORWARD_EN: reads hitting the buffered line are served
// straight from the buffer instead of forcing a drain first.
module cbus_writeback_buffer
    import cbus_writeback_buffer_pkg::*;
#(
    parameter int LINE_WORDS  = WB_LINE_WORDS,
    parameter int OFFSET_BITS = $clog2(LINE_WORDS) + 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  in_req,
    output cbus_resp_t in_resp,
    output cbus_req_t  out_req,
    input  cbus_resp_t out_resp,
    output logic       wb_busy
);

    localparam int              IDXW     = $clog2(LINE_WORDS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LINE_WORDS - 1);

    wb_state_t       state;
    logic [IDXW-1:0] acnt;      // absorb beat index
    logic [IDXW-1:0] dcnt;      // drain beat index
    logic [IDXW-1:0] ridx;
    logic            buf_valid;
    logic [31:0]     buf_tag;
    logic [31:0]     buf_rdata;
    logic            conflict;
    logic            absorbable;
    logic            drain_done;

    assign conflict   = buf_valid && (line_base(in_req.addr, OFFSET_BITS) == buf_tag);
    assign absorbable = in_req.is_write && (in_req.len == 4'(LINE_WORDS - 1)) && (in_req.strobe == 4'hf);
    assign drain_done = (state == DRAIN) && out_resp.ready && out_resp.last;

`ifdef WB_FORWARD_EN
    logic       fwd;            // current PASS is served from the buffer
    logic [3:0] fcnt;
    logic       fwd_last;
    assign fwd_last = (fcnt == in_req.len);
    // Forwarded beats walk the line starting at the requested word, wrapping.
    assign ridx = (state == DRAIN) ? dcnt : in_req.addr[OFFSET_BITS-1:2] + fcnt[IDXW-1:0];
`else
    assign ridx = dcnt;
`endif

    wb_line_store #(.LINE_WORDS(LINE_WORDS)) u_store (
        .clk       (clk),
        .resetn    (resetn),
        .we        (state == ABSORB),
        .widx      (acnt),
        .wdata     (in_req.data),
        .wtag      (line_base(in_req.addr, OFFSET_BITS)),
        .set_valid ((state == ABSORB) && (acnt == LAST_IDX)),
        .clr_valid (drain_done),
        .ridx      (ridx),
        .rdata     (buf_rdata),
        .valid     (buf_valid),
        .tag       (buf_tag)
    );

    // Control FSM: IDLE arbitrates, every other state runs one transaction to completion.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            acnt  <= '0;
            dcnt  <= '0;
`ifdef WB_FORWARD_EN
            fwd   <= 1'b0;
            fcnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_req.valid) begin
                        if (!in_req.is_write) begin
                            if (conflict) begin
`ifdef WB_FORWARD_EN
                                state <= PASS;
                                fwd   <= 1'b1;
                                fcnt  <= '0;
`else
                                state <= DRAIN;
`endif
                            end else begin
                                state <= PASS;
                            end
                        end else if (absorbable) begin
                            state <= buf_valid ? DRAIN : ABSORB;
                        end else begin
                            state <= buf_valid ? DRAIN : PASS;
                        end
                    end else if (buf_valid) begin
                        state <= DRAIN;
                    end
                end
                ABSORB: begin
                    acnt <= acnt + IDXW'(1);
                    if (acnt == LAST_IDX) state <= IDLE;
                end
                PASS: begin
`ifdef WB_FORWARD_EN
                    if (fwd) begin
                        fcnt <= fcnt + 4'd1;
                        if (fwd_last) begin
                            fwd   <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (out_resp.ready && out_resp.last) begin
                        state <= IDLE;
                    end
`else
                    if (out_resp.ready && out_resp.last) state <= IDLE;
`endif
                end
                DRAIN: begin
                    if (out_resp.ready) begin
                        dcnt <= dcnt + IDXW'(1);
                        if (out_resp.last) begin
                            dcnt  <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus outputs decoded from state; PASS must be a combinational feed-through.
    always_comb begin
        in_resp = '0;
        out_req = '0;
        case (state)
            ABSORB: begin
                in_resp.ready = 1'b1;
                in_resp.last  = (acnt == LAST_IDX);
            end
            PASS: begin
`ifdef WB_FORWARD_EN
                if (fwd) begin
                    in_resp.ready = 1'b1;
                    in_resp.last  = fwd_last;
                    in_resp.data  = buf_rdata;
                end else begin
                    out_req = in_req;
                    in_resp = out_resp;
                end
`else
                out_req = in_req;
                in_resp = out_resp;
`endif
            end
            DRAIN: begin
                out_req.valid    = 1'b1;
                out_req.is_write = 1'b1;
                out_req.size     = 3'd2;
                out_req.addr     = buf_tag;
                out_req.strobe   = 4'hf;
                out_req.data     = buf_rdata;
                out_req.len      = 4'(LINE_WORDS - 1);
            end
            default: ;
        endcase
    end

    assign wb_busy = buf_valid || (state == DRAIN);

endmodule

// File: tb/tb_cbus_writeback_buffer.sv
// Self-checking bench for cbus_writeback_buffer: directed scenarios plus a
// randomized op stream checked against a flat program-order memory model.
module tb_cbus_writeback_buffer;
    import cbus_writeback_buffer_pkg::*;

    logic       clk;
    logic       resetn;
    cbus_req_t  in_req;
    cbus_resp_t in_resp;
    cbus_req_t  out_req;
    cbus_resp_t out_resp;
    logic       wb_busy;

    int checks   = 0;
    int failures = 0;

    cbus_writeback_buffer dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_req   (in_req),
        .in_resp  (in_resp),
        .out_req  (out_req),
        .out_resp (out_resp),
        .wb_busy  (wb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory side model and reference memory
    logic [31:0] mem_m   [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int  mem_beat    = 0;
    int  wr_beats    = 0;
    int  oreq_cycles = 0;
    bit  mem_stall_en = 0;

    function automatic logic [31:0] mget(input logic [31:0] a);
        return mem_m.exists(a) ? mem_m[a] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_get(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s[i]) o[8*i +: 8] = d[8*i +: 8];
        return o;
    endfunction

    // Memory drives its response mid-cycle from the current request
    always @(negedge clk) begin
        if (out_req.valid) begin
            out_resp.ready = mem_stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            out_resp.last  = (mem_beat == int'(out_req.len));
            out_resp.data  = out_req.is_write ? 32'h0 : mget(out_req.addr + 32'(4 * mem_beat));
        end else begin
            out_resp = '0;
        end
    end

    // Memory commits accepted beats at the clock edge
    always @(posedge clk) begin
        if (out_req.valid) oreq_cycles++;
        if (!resetn) begin
            mem_beat = 0;
        end else if (out_req.valid && out_resp.ready) begin
            if (out_req.is_write) begin
                mem_m[out_req.addr + 32'(4 * mem_beat)] =
                    merge(mget(out_req.addr + 32'(4 * mem_beat)), out_req.data, out_req.strobe);
                wr_beats++;
            end
            if (out_resp.last) mem_beat = 0;
            else               mem_beat++;
        end
    end

    // Master driver results
    logic [31:0] got_q[$];
    int          t_wait, t_span, t_first_oreq, wr_at_first;
    logic [31:0] first_oreq_addr;
    logic        first_oreq_wr;

    // Issue one request (entered at posedge+1), per-beat write data in wd.
    task automatic run_req(input cbus_req_t r, input logic [3:0][31:0] wd);
        int  c;
        int  nb;
        bit  done;
        bit  acc;
        got_q.delete();
        t_wait = -1; t_first_oreq = -1; c = 0; nb = 0; done = 0;
        in_req = r;
        in_req.data = wd[0];
        while (!done && c < 300) begin
            @(negedge clk); #1;
            acc = 0;
            if (out_req.valid && t_first_oreq < 0) begin
                t_first_oreq    = c;
                first_oreq_addr = out_req.addr;
                first_oreq_wr   = out_req.is_write;
            end
            if (in_resp.ready) begin
                if (t_wait < 0) begin
                    t_wait      = c;
                    wr_at_first = wr_beats;
                end
                got_q.push_back(in_resp.data);
                if (r.is_write)
                    ref_mem[r.addr + 32'(4 * nb)] = merge(ref_get(r.addr + 32'(4 * nb)), wd[nb], r.strobe);
                done = in_resp.last;
                acc  = 1;
            end
            @(posedge clk); #1;
            c++;
            if (acc) begin
                nb++;
                if (nb < 4) in_req.data = wd[nb];
            end
        end
        t_span = c - t_wait;
        in_req = '0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL req_timeout: addr %h no ready&last within %0d cycles", r.addr, c);
        end
    endtask

    function automatic cbus_req_t mk_burst(input logic [31:0] a);
        cbus_req_t r;
        r = '0; r.valid = 1'b1; r.is_write = 1'b1; r.size = 3'd2;
        r.addr = a; r.strobe = 4'hf; r.len = 4'd3;
        return r;
    endfunction

    function automatic cbus_req_t mk_read(input logic [31:0] a, input logic [3:0] len);
        cbus_req_t r;
        r = '0; r.valid = 1'b1; r.size = 3'd2; r.addr = a; r.len = len;
        return r;
    endfunction

    task automatic wait_idle();
        int c;
        c = 0;
        while (wb_busy && c < 300) begin
            @(negedge clk); #1;
            c++;
        end
        checks++;
        if (wb_busy) begin
            failures++;
            $display("FAIL idle_timeout: wb_busy still %b after %0d cycles", wb_busy, c);
        end
        @(posedge clk); #1;
    endtask

    localparam logic [3:0][31:0] LINE_D = {32'h44, 32'h33, 32'h22, 32'h11};

    task automatic test_reset();
        resetn = 1'b0;
        in_req = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_resp !== '0) begin failures++; $display("FAIL reset_in_resp: got %h exp 0", in_resp); end
        checks++; if (out_req !== '0) begin failures++; $display("FAIL reset_out_req: got %h exp 0", out_req); end
        checks++; if (wb_busy !== 1'b0) begin failures++; $display("FAIL reset_wb_busy: got %b exp 0", wb_busy); end
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_conflict();
        int wb0;
        run_req(mk_burst(32'h8000_0040), LINE_D);
        checks++; if (t_span !== 4 || t_wait !== 1) begin failures++; $display("FAIL conf_absorb_lat: wait %0d span %0d exp 1 4", t_wait, t_span); end
        wb0 = wr_beats;
        run_req(mk_read(32'h8000_0048, 4'd1), '0);
        checks++; if (got_q.size() !== 2) begin failures++; $display("FAIL conf_beats: got %0d exp 2", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== 32'h33) begin failures++; $display("FAIL conf_beat0: got %h exp 33", got_q[0]); end
            checks++; if (got_q[1] !== 32'h44) begin failures++; $display("FAIL conf_beat1: got %h exp 44", got_q[1]); end
        end
`ifdef WB_FORWARD_EN
        checks++; if (t_wait !== 1) begin failures++; $display("FAIL fwd_first_cycle: got %0d exp 1", t_wait); end
        checks++; if (t_first_oreq !== -1) begin failures++; $display("FAIL fwd_no_oreq: out_req seen at %0d exp none", t_first_oreq); end
        checks++; if (wb_busy !== 1'b1) begin failures++; $display("FAIL fwd_buf_kept: wb_busy %b exp 1", wb_busy); end
`else
        checks++; if (first_oreq_wr !== 1'b1 || first_oreq_addr !== 32'h8000_0040) begin
            failures++; $display("FAIL conf_drain_first: wr %b addr %h exp 1 80000040", first_oreq_wr, first_oreq_addr); end
        checks++; if (wr_at_first !== wb0 + 4) begin failures++; $display("FAIL conf_drain_done: beats %0d exp %0d", wr_at_first, wb0 + 4); end
`endif
        wait_idle();
    endtask

    task automatic test_absorb_refill();
        int oc0, wb0;
        oc0 = oreq_cycles;
        run_req(mk_burst(32'h8000_0040), LINE_D);
        checks++; if (t_wait !== 1 || t_span !== 4) begin failures++; $display("FAIL absorb_lat: wait %0d span %0d exp 1 4", t_wait, t_span); end
        checks++; if (oreq_cycles !== oc0) begin failures++; $display("FAIL absorb_no_mem: oreq cycles %0d exp %0d", oreq_cycles, oc0); end
        wb0 = wr_beats;
        run_req(mk_read(32'h8000_1000, 4'd0), '0);
        checks++; if (t_first_oreq !== 1 || first_oreq_wr !== 1'b0 || first_oreq_addr !== 32'h8000_1000) begin
            failures++; $display("FAIL refill_first: at %0d wr %b addr %h exp 1 0 80001000", t_first_oreq, first_oreq_wr, first_oreq_addr); end
        checks++; if (got_q.size() !== 1 || got_q[0] !== ref_get(32'h8000_1000)) begin
            failures++; $display("FAIL refill_data: got %h exp %h", got_q[0], ref_get(32'h8000_1000)); end
        checks++; if (wr_beats !== wb0) begin failures++; $display("FAIL refill_before_drain: write beats %0d exp %0d", wr_beats, wb0); end
        wait_idle();
        checks++; if (wr_beats !== wb0 + 4) begin failures++; $display("FAIL refill_drain_after: beats %0d exp %0d", wr_beats, wb0 + 4); end
    endtask

    task automatic test_idle_drain();
        int  beat;
        bit  lastseen, done;
        beat = 0; lastseen = 0; done = 0;
        run_req(mk_burst(32'h8000_0100), LINE_D);
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk); #1;
            if (out_req.valid && out_resp.ready) begin
                checks++;
                if (out_req.addr !== 32'h8000_0100 || out_req.len !== 4'd3 || out_req.is_write !== 1'b1 ||
                    out_req.strobe !== 4'hf || out_req.data !== LINE_D[beat & 3]) begin
                    failures++;
                    $display("FAIL drain_beat%0d: addr %h len %0d wr %b strb %h data %h exp 80000100 3 1 f %h",
                             beat, out_req.addr, out_req.len, out_req.is_write, out_req.strobe, out_req.data, LINE_D[beat & 3]);
                end
                if (out_resp.last) begin
                    checks++; if (beat !== 3) begin failures++; $display("FAIL drain_len: last on beat %0d exp 3", beat); end
                    checks++; if (wb_busy !== 1'b1) begin failures++; $display("FAIL drain_busy: wb_busy %b exp 1", wb_busy); end
                    lastseen = 1;
                end
                beat++;
            end
            @(posedge clk); #1;
            if (lastseen) begin
                checks++; if (wb_busy !== 1'b0) begin failures++; $display("FAIL drain_busy_drop: wb_busy %b exp 0", wb_busy); end
                done = 1;
            end
        end
        checks++; if (!done) begin failures++; $display("FAIL drain_timeout: beats %0d exp 4", beat); end
    endtask

    task automatic test_back_to_back();
        int wb0;
        run_req(mk_burst(32'h8000_0200), LINE_D);
        wb0 = wr_beats;
        run_req(mk_burst(32'h8000_0240), {32'hd4, 32'hc3, 32'hb2, 32'ha1});
        checks++; if (wr_at_first !== wb0 + 4) begin failures++; $display("FAIL b2b_drain_first: beats %0d exp %0d", wr_at_first, wb0 + 4); end
        checks++; if (t_span !== 4) begin failures++; $display("FAIL b2b_absorb_span: got %0d exp 4", t_span); end
        checks++; if (mget(32'h8000_0208) !== 32'h33) begin failures++; $display("FAIL b2b_mem: got %h exp 33", mget(32'h8000_0208)); end
        wait_idle();
    endtask

    task automatic test_random();
        cbus_req_t        r;
        logic [3:0][31:0] wd;
        logic [31:0]      base, a;
        int               op, w;
        mem_stall_en = 1;
        for (int n = 0; n < 60; n++) begin
            base = 32'h8000_0000 + 32'(16 * $urandom_range(0, 3));
            op   = $urandom_range(0, 2);
            w    = $urandom_range(0, 3);
            wd   = {$urandom, $urandom, $urandom, $urandom};
            case (op)
                0: r = mk_burst(base);
                1: begin
                    r = mk_burst(base + 32'(4 * w));
                    r.len = 4'd0;
                    r.strobe = 4'($urandom_range(1, 15));
                end
                default: r = mk_read(base + 32'(4 * w), 4'($urandom_range(0, 3 - w)));
            endcase
            run_req(r, wd);
            if (!r.is_write) begin
                checks++;
                if (got_q.size() !== int'(r.len) + 1) begin
                    failures++; $display("FAIL rnd_read_len: got %0d exp %0d", got_q.size(), int'(r.len) + 1);
                end else begin
                    for (int k = 0; k <= int'(r.len); k++) begin
                        a = r.addr + 32'(4 * k);
                        checks++;
                        if (got_q[k] !== ref_get(a)) begin
                            failures++; $display("FAIL rnd_read %h: got %h exp %h", a, got_q[k], ref_get(a));
                        end
                    end
                end
            end
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
        end
        wait_idle();
        for (int l = 0; l < 4; l++) begin
            for (int k = 0; k < 4; k++) begin
                a = 32'h8000_0000 + 32'(16 * l + 4 * k);
                checks++;
                if (mget(a) !== ref_get(a)) begin
                    failures++; $display("FAIL rnd_mem %h: got %h exp %h", a, mget(a), ref_get(a));
                end
            end
        end
        mem_stall_en = 0;
    endtask

    task automatic test_reset_mid_absorb();
        int  nready, oc0, wb0;
        bit  hit;
        nready = 0; hit = 0;
        in_req = mk_burst(32'h8000_0300);
        in_req.data = 32'h11;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk); #1;
            if (in_resp.ready) begin
                if (nready == 2) begin
                    resetn = 1'b0;
                    in_req = '0;
                    hit = 1;
                end
                nready++;
            end
            @(posedge clk); #1;
        end
        checks++; if (!hit) begin failures++; $display("FAIL rst_mid_reach: ready beats %0d exp 3", nready); end
        checks++; if (in_resp !== '0 || out_req !== '0) begin
            failures++; $display("FAIL rst_mid_outs: in_resp %h out_req %h exp 0", in_resp, out_req); end
        checks++; if (wb_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b exp 0", wb_busy); end
        resetn = 1'b1;
        oc0 = oreq_cycles; wb0 = wr_beats;
        repeat (30) @(posedge clk);
        #1;
        checks++; if (oreq_cycles !== oc0 || wr_beats !== wb0) begin
            failures++; $display("FAIL rst_mid_no_drain: oreq cycles %0d beats %0d exp %0d %0d", oreq_cycles, wr_beats, oc0, wb0); end
        checks++; if (wb_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy_after: got %b exp 0", wb_busy); end
    endtask

    initial begin
        in_req = '0;
        resetn = 1'b0;
        test_reset();
        test_read_conflict();
        test_absorb_refill();
        test_idle_drain();
        test_back_to_back();
        test_random();
        test_reset_mid_absorb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
